// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the cache-line transfer engine.
//   xfer_state_t : FSM states of mem_line_xfer
//   WORD_W       : memory word width in bits
//   line_words() : words per cache line from log2 line size
package mem_xfer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_TAIL,
    DONE
  } xfer_state_t;

  localparam int WORD_W = 32;

  function automatic int line_words(input int line_words_len);
    return 1 << line_words_len;
  endfunction

endpackage

// File: rtl/mem_line_xfer_if.sv
// Bundle of the cache-controller request/grant signals and the word-memory
// bus seen by mem_line_xfer.
//   master : the transfer engine (takes requests, drives the memory bus)
//   slave  : the requester plus word memory (drives requests, returns rd_data)
interface mem_line_xfer_if #(
  parameter int ADDR_LEN       = 11,
  parameter int LINE_WORDS_LEN = 3
);
  import mem_xfer_pkg::*;

  localparam int N    = line_words(LINE_WORDS_LEN);
  localparam int LA_W = ADDR_LEN - LINE_WORDS_LEN;

  logic                  rd_req;
  logic                  wr_req;
  logic [LA_W-1:0]       line_addr;
  logic [WORD_W*N-1:0]   wr_line;
  logic [WORD_W*N-1:0]   rd_line;
  logic                  gnt;
  logic                  busy;
  logic [ADDR_LEN-1:0]   mem_addr;
  logic                  mem_wr_req;
  logic [WORD_W-1:0]     mem_wr_data;
  logic [WORD_W-1:0]     mem_rd_data;

  modport master (
    input  rd_req, wr_req, line_addr, wr_line, mem_rd_data,
    output rd_line, gnt, busy, mem_addr, mem_wr_req, mem_wr_data
  );

  modport slave (
    output rd_req, wr_req, line_addr, wr_line, mem_rd_data,
    input  rd_line, gnt, busy, mem_addr, mem_wr_req, mem_wr_data
  );

endinterface

// File: rtl/mem_line_xfer.sv
// Cache-line transfer engine: converts one line refill (read) or writeback
// (write) request into LINE_WORDS consecutive accesses on a single-port word
// memory with one-cycle registered read latency, then pulses gnt for one cycle.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   bus.master   rd_req/wr_req/line_addr/wr_line in, rd_line/gnt/busy out,
//                mem_addr/mem_wr_req/mem_wr_data out, mem_rd_data in
//   perf_rd_cnt  completed line reads  (only with MEM_LINE_XFER_PERF_EN)
//   perf_wr_cnt  completed line writes (only with MEM_LINE_XFER_PERF_EN)
//
// Optional feature macro: MEM_LINE_XFER_PERF_EN adds the two 32-bit wrapping
// transaction counters.
module mem_line_xfer
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_LEN       = 11,
  parameter int LINE_WORDS_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  mem_line_xfer_if.master bus
`ifdef MEM_LINE_XFER_PERF_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt
`endif
);

  localparam int N    = line_words(LINE_WORDS_LEN);
  localparam int LA_W = ADDR_LEN - LINE_WORDS_LEN;

  xfer_state_t               state_q, state_d;
  logic [LINE_WORDS_LEN-1:0] k_q, k_d;
  logic [LA_W-1:0]           addr_q, addr_d;
  logic [WORD_W*N-1:0]       wr_line_q, wr_line_d;
  logic [WORD_W*N-1:0]       rd_line_q, rd_line_d;
  logic                      k_last;
  logic [LINE_WORDS_LEN-1:0] k_prev;

  assign k_last = (k_q == {LINE_WORDS_LEN{1'b1}});
  assign k_prev = k_q - 1'b1;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_d    = addr_q;
    wr_line_d = wr_line_q;
    rd_line_d = rd_line_q;
    case (state_q)
      IDLE: begin
        // Write wins a simultaneous request; the read stays pending.
        if (bus.wr_req) begin
          state_d   = WRITE;
          addr_d    = bus.line_addr;
          wr_line_d = bus.wr_line;
          k_d       = '0;
        end else if (bus.rd_req) begin
          state_d = READ;
          addr_d  = bus.line_addr;
          k_d     = '0;
        end
      end
      WRITE: begin
        k_d = k_q + 1'b1;
        if (k_last) state_d = DONE;
      end
      READ: begin
        // Read data trails the address by one cycle: word k-1 arrives now.
        if (k_q != '0) rd_line_d[WORD_W*int'(k_prev) +: WORD_W] = bus.mem_rd_data;
        if (k_last) state_d = READ_TAIL;  // k held so mem_addr keeps its value
        else        k_d = k_q + 1'b1;
      end
      READ_TAIL: begin
        rd_line_d[WORD_W*int'(k_q) +: WORD_W] = bus.mem_rd_data;
        k_d     = '0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      wr_line_q <= '0;
      rd_line_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      wr_line_q <= wr_line_d;
      rd_line_q <= rd_line_d;
    end
  end

  // Outputs decoded from registered state only.
  assign bus.mem_addr    = {addr_q, k_q};
  assign bus.mem_wr_req  = (state_q == WRITE);
  assign bus.mem_wr_data = (state_q == WRITE) ? wr_line_q[WORD_W*int'(k_q) +: WORD_W] : '0;
  assign bus.rd_line     = rd_line_q;
  assign bus.gnt         = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);

`ifdef MEM_LINE_XFER_PERF_EN
  logic        is_wr_q;
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q   <= 1'b0;
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      // Remember the kind of transaction accepted, for counting at DONE.
      if (state_q == IDLE && bus.wr_req)      is_wr_q <= 1'b1;
      else if (state_q == IDLE && bus.rd_req) is_wr_q <= 1'b0;
      if (state_q == DONE) begin
        if (is_wr_q) perf_wr_q <= perf_wr_q + 32'd1;
        else         perf_rd_q <= perf_rd_q + 32'd1;
      end
    end
  end

  assign perf_rd_cnt = perf_rd_q;
  assign perf_wr_cnt = perf_wr_q;
`endif

endmodule

// File: tb/tb_mem_line_xfer.sv
module tb_mem_line_xfer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_line_xfer_if #(.ADDR_LEN(11), .LINE_WORDS_LEN(3)) bus ();

`ifdef MEM_LINE_XFER_PERF_EN
  logic [31:0] perf_rd_cnt;
  logic [31:0] perf_wr_cnt;
`endif

  mem_line_xfer #(.ADDR_LEN(11), .LINE_WORDS_LEN(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef MEM_LINE_XFER_PERF_EN
    ,
    .perf_rd_cnt (perf_rd_cnt),
    .perf_wr_cnt (perf_wr_cnt)
`endif
  );

  // Word memory: 1-cycle registered read, plus a preload port for the bench.
  logic [31:0] mem [0:2047];
  logic [31:0] rd_q;
  logic        pl_we = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (bus.mem_wr_req) mem[bus.mem_addr] <= bus.mem_wr_data;
    rd_q <= mem[bus.mem_addr];
  end
  assign bus.mem_rd_data = rd_q;

  // Reference model state
  logic [31:0]  ref_mem [0:2047];
  logic [255:0] exp_rd;
  int           rd_done, wr_done;
  int           errors = 0;
  int           checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] ref_line(input logic [7:0] line);
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = ref_mem[{line, 3'(i)}];
    return v;
  endfunction

  // One complete line transaction, checked against the model.
  task automatic do_xfer(input bit is_wr, input logic [7:0] line, input logic [255:0] data,
                         input bit scramble, input string tag);
    int cyc, nwr;
    bit trace_ok, busy_ok;
    @(negedge clk);
    bus.line_addr = line;
    bus.wr_line   = data;
    if (is_wr) bus.wr_req = 1'b1;
    else       bus.rd_req = 1'b1;
    cyc = 0; nwr = 0; trace_ok = 1'b1; busy_ok = 1'b1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (scramble) begin
        bus.line_addr = 8'($urandom);
        bus.wr_line   = rand256();
      end
      if (bus.gnt) break;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.mem_wr_req) begin
        if (!is_wr || nwr >= 8 || cyc != nwr + 1 || bus.mem_addr !== {line, 3'(nwr)} ||
            bus.mem_wr_data !== data[32*nwr +: 32]) trace_ok = 1'b0;
        nwr++;
      end
    end
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    if (is_wr) begin
      for (int i = 0; i < 8; i++) ref_mem[{line, 3'(i)}] = data[32*i +: 32];
      wr_done++;
    end else begin
      exp_rd = ref_line(line);
      rd_done++;
    end
    chk({tag, "_lat"}, 256'(cyc), is_wr ? 256'd9 : 256'd10);
    chk({tag, "_rdline"}, bus.rd_line, exp_rd);
    chk({tag, "_trace"}, {255'd0, trace_ok && busy_ok && (nwr == (is_wr ? 8 : 0))}, 256'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, {254'd0, bus.gnt, bus.busy}, 256'd0);
  endtask

  logic [7:0]   line;
  logic [255:0] data;
  logic [255:0] t1_line;
  int           cyc, ngnt;
  bit           wr_first;
  bit           mem_ok;

  initial begin
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    bus.line_addr = '0;
    bus.wr_line = '0;
    exp_rd = '0;
    rd_done = 0;
    wr_done = 0;
    t1_line = {32'hde, 32'hd8, 32'h3c, 32'had, 32'h2a, 32'h91, 32'h68, 32'h8a};

    // Preload memory while held in reset.
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = 11'(i);
      pl_data = (i < 8) ? t1_line[32*i +: 32] : $urandom;
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_we = 1'b0;

    chk("rst_rd_line", bus.rd_line, 256'd0);
    chk("rst_gnt", 256'(bus.gnt), 256'd0);
    chk("rst_busy", 256'(bus.busy), 256'd0);
    chk("rst_mem_addr", 256'(bus.mem_addr), 256'd0);
    chk("rst_mem_wr_req", 256'(bus.mem_wr_req), 256'd0);
    chk("rst_mem_wr_data", 256'(bus.mem_wr_data), 256'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Refill of preloaded line 0
    do_xfer(1'b0, 8'd0, '0, 1'b0, "t1");
    chk("t1_w0", 256'(bus.rd_line[31:0]), 256'h8a);
    chk("t1_w7", 256'(bus.rd_line[255:224]), 256'hde);

    // Writeback of line 5, then read it back
    for (int i = 0; i < 8; i++) data[32*i +: 32] = 32'h1000 + 32'(i);
    do_xfer(1'b1, 8'd5, data, 1'b0, "t2w");
    do_xfer(1'b0, 8'd5, '0, 1'b0, "t2r");
    chk("t2_w0", 256'(bus.rd_line[31:0]), 256'h1000);
    chk("t2_w7", 256'(bus.rd_line[255:224]), 256'h1007);

    // Simultaneous requests: write first, then the pending read
    @(negedge clk);
    data = rand256();
    bus.line_addr = 8'd3;
    bus.wr_line = data;
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    cyc = 0; ngnt = 0; wr_first = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_wr_req && ngnt == 0) wr_first = 1'b1;
      if (bus.gnt) begin
        ngnt++;
        if (ngnt == 1) bus.wr_req = 1'b0;
        else           bus.rd_req = 1'b0;
      end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[{8'd3, 3'(i)}] = data[32*i +: 32];
    exp_rd = data;
    wr_done++;
    rd_done++;
    chk("t3_ngnt", 256'(ngnt), 256'd2);
    chk("t3_wr_first", 256'(wr_first), 256'd1);
    chk("t3_rdline", bus.rd_line, exp_rd);

    // Random mix: write a random line, read it back, read another line
    for (int r = 0; r < 4; r++) begin
      line = 8'($urandom);
      do_xfer(1'b1, line, rand256(), 1'b0, "rnd_w");
      do_xfer(1'b0, line, '0, 1'b0, "rnd_r");
      do_xfer(1'b0, 8'($urandom), '0, 1'b0, "rnd_r2");
    end

    // Reset in the middle of a read at k=4
    @(negedge clk);
    bus.line_addr = 8'd9;
    bus.rd_req = 1'b1;
    cyc = 0;
    while (cyc < 40 && !(bus.busy && bus.mem_addr[2:0] == 3'd4)) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_reached_k4", 256'(cyc), 256'd5);
    rst = 1'b0;
    #1;
    chk("t4_busy", 256'(bus.busy), 256'd0);
    chk("t4_gnt", 256'(bus.gnt), 256'd0);
    chk("t4_mem_wr_req", 256'(bus.mem_wr_req), 256'd0);
    chk("t4_rd_line", bus.rd_line, 256'd0);
    bus.rd_req = 1'b0;
    exp_rd = '0;
    rd_done = 0;
    wr_done = 0;
    @(negedge clk);
    rst = 1'b1;
    do_xfer(1'b0, 8'd0, '0, 1'b0, "t4r");

    // Inputs scrambled every cycle during a write
    line = 8'd77;
    data = rand256();
    do_xfer(1'b1, line, data, 1'b1, "t5w");
    do_xfer(1'b0, line, '0, 1'b0, "t5r");
    chk("t5_data", bus.rd_line, data);
    mem_ok = 1'b1;
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) mem_ok = 1'b0;
    chk("mem_all", 256'(mem_ok), 256'd1);

`ifdef MEM_LINE_XFER_PERF_EN
    chk("perf_rd", 256'(perf_rd_cnt), 256'(rd_done));
    chk("perf_wr", 256'(perf_wr_cnt), 256'(wr_done));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
